// File: rtl/xfire_pkg.sv
// Shared constants for the xfire scheduler slice: FSM encodings and parameter defaults.
package xfire_pkg;

  localparam logic [1:0] XFIRE_SCHED_IDLE  = 2'd0;
  localparam logic [1:0] XFIRE_SCHED_START = 2'd1;
  localparam logic [1:0] XFIRE_SCHED_WAIT  = 2'd2;
  localparam logic [1:0] XFIRE_SCHED_ACK   = 2'd3;

  localparam int XFIRE_NREQ_DEF    = 4;
  localparam int XFIRE_TIMEOUT_DEF = 255;

endpackage

// File: rtl/xfire_rr_arb.sv
// Combinational round-robin picker: first set request at or above i_rr_ptr, wrapping at NREQ-1.
module xfire_rr_arb
  import xfire_pkg::*;
#(
  parameter int NREQ = XFIRE_NREQ_DEF,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_rr_ptr,
  output logic            o_valid,
  output logic [NREQ-1:0] o_onehot,
  output logic [IDW-1:0]  o_idx
);

  logic [IDW-1:0] w_slot [NREQ];

  // w_slot[g] is the requester index examined at scan offset g from the pointer.
  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    logic [IDW:0] w_sum;
    assign w_sum     = {1'b0, i_rr_ptr} + (IDW+1)'(g);
    assign w_slot[g] = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : IDW'(w_sum);
  end

  // Scanning from the farthest offset down lets the nearest pending request overwrite the others.
  always_comb begin
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[w_slot[i]]) begin
        o_valid = 1'b1;
        o_idx   = w_slot[i];
      end
    end
    if (o_valid) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/xfire_sched.sv
// Round-robin scheduler sharing one xfire_core among NREQ requesters.
// Optional WAIT timeout/abort path enabled by defining XFIRE_SCHED_TIMEOUT_EN.
module xfire_sched
  import xfire_pkg::*;
#(
  parameter int NREQ    = XFIRE_NREQ_DEF,
  parameter int IDW     = 2,
  parameter int TOW     = 8,
  parameter int TIMEOUT = XFIRE_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            srst,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  input  logic            core_done,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            core_start,
  output logic [NREQ-1:0] ack,
  output logic            busy,
  output logic            timeout_err,
  output logic [1:0]      o_state
);

  if (IDW != $clog2(NREQ) || TIMEOUT < 1 || TIMEOUT > (2**TOW) - 1) begin : g_cfg_err
    $error("xfire_sched: inconsistent NREQ/IDW/TOW/TIMEOUT");
  end

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [NREQ-1:0] r_grant;
  logic [IDW-1:0]  r_grant_id;
  logic            r_core_start;
  logic [NREQ-1:0] r_ack;
  logic            r_busy;
  logic            r_timeout_err;

  logic            w_valid;
  logic [NREQ-1:0] w_onehot;
  logic [IDW-1:0]  w_idx;
  logic            w_timeout;
  logic [IDW-1:0]  w_ptr_next;

  xfire_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_valid),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  assign w_ptr_next = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + IDW'(1);

`ifdef XFIRE_SCHED_TIMEOUT_EN
  logic [TOW-1:0] r_cnt;

  // Counts completed WAIT cycles; the abort fires on the TIMEOUT-th one.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)     r_cnt <= '0;
    else if (srst)   r_cnt <= '0;
    else if (enable) r_cnt <= (r_state == XFIRE_SCHED_WAIT && !w_timeout) ? r_cnt + TOW'(1) : '0;
  end

  assign w_timeout = (r_state == XFIRE_SCHED_WAIT) && (r_cnt == TOW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n || srst) begin
      r_state       <= XFIRE_SCHED_IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_core_start  <= 1'b0;
      r_ack         <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (!enable) begin
      r_core_start  <= 1'b0;
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_core_start  <= 1'b0;
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        XFIRE_SCHED_IDLE: begin
          if (w_valid) begin
            r_state      <= XFIRE_SCHED_START;
            r_grant      <= w_onehot;
            r_grant_id   <= w_idx;
            r_core_start <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        XFIRE_SCHED_START: r_state <= XFIRE_SCHED_WAIT;
        XFIRE_SCHED_WAIT: begin
          // A real completion takes precedence over a simultaneous timeout.
          if (core_done || w_timeout) begin
            r_state       <= XFIRE_SCHED_ACK;
            r_ack         <= r_grant;
            r_timeout_err <= !core_done;
          end
        end
        XFIRE_SCHED_ACK: begin
          r_state  <= XFIRE_SCHED_IDLE;
          r_grant  <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_ptr_next;
        end
        default: r_state <= XFIRE_SCHED_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign core_start  = r_core_start;
  assign ack         = r_ack;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign o_state     = r_state;

`ifdef RTL_DEBUG
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(r_grant));
  a_start_in_start: assert property (@(posedge clk) disable iff (!arst_n)
    r_core_start |-> (r_state == XFIRE_SCHED_START));
  a_ack_is_grant: assert property (@(posedge clk) disable iff (!arst_n)
    (r_ack != '0) |-> (r_ack == r_grant));
`endif

endmodule

// File: tb/tb_xfire_sched.sv
// Self-checking bench for xfire_sched: expected grants queued at request time, checked at core_start/ack.
module tb_xfire_sched;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TOW     = 8;
  localparam int TIMEOUT = 10;

  logic            clk;
  logic            arst_n;
  logic            srst;
  logic            enable;
  logic [NREQ-1:0] req;
  logic            core_done;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            core_start;
  logic [NREQ-1:0] ack;
  logic            busy;
  logic            timeout_err;
  logic [1:0]      state;

  logic [NREQ-1:0] exp_q[$];
  int n_cmp;
  int n_err;
  int m_ptr;

  xfire_sched #(.NREQ(NREQ), .IDW(IDW), .TOW(TOW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .srst        (srst),
    .enable      (enable),
    .req         (req),
    .core_done   (core_done),
    .grant       (grant),
    .grant_id    (grant_id),
    .core_start  (core_start),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .o_state     (state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  // Drive requests, queue the expected winner, and check the grant when core_start appears.
  task automatic start_txn(input logic [NREQ-1:0] rv, output int w);
    bit found;
    logic [NREQ-1:0] e;
    req = rv;
    w = pick(rv, m_ptr);
    exp_q.push_back(NREQ'(1) << w);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (core_start) found = 1'b1;
    end
    chk("start_seen", 32'(found), 32'd1);
    e = exp_q.pop_front();
    chk("grant", 32'(grant), 32'(e));
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("busy_high", 32'(busy), 32'd1);
  endtask

  // Let the core run dly cycles, pulse core_done, check the ack pulse and the return to idle.
  task automatic finish_txn(input int w, input int dly, input bit drop);
    int starts;
    starts = 0;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      if (core_start) starts++;
    end
    if (dly > 0) chk("single_start", 32'(starts), 32'd0);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("ack", 32'(ack), 32'(NREQ'(1) << w));
    chk("no_timeout_err", 32'(timeout_err), 32'd0);
    if (drop) req[w] = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("busy_low", 32'(busy), 32'd0);
    m_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    int w;
    int cyc;
    int order[5];
    n_cmp = 0;
    n_err = 0;
    m_ptr = 0;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    arst_n = 1'b0;
    srst = 1'b0;
    enable = 1'b1;
    req = '0;
    core_done = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // core_done while idle must be ignored
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_ack", 32'(ack), 32'd0);

    // single requester 2, done 3 cycles after start
    start_txn(4'b0100, w);
    chk("t1_grant", 32'(grant), 32'h4);
    finish_txn(w, 3, 1'b1);

    // pointer now 3: 1001 serves 3 then wraps to 0
    start_txn(4'b1001, w);
    chk("wrap_first", 32'(grant_id), 32'd3);
    finish_txn(w, 1, 1'b1);
    start_txn(req, w);
    chk("wrap_second", 32'(grant_id), 32'd0);
    finish_txn(w, 2, 1'b1);

    // srst during START: back to idle, pointer cleared
    start_txn(4'b0100, w);
    srst = 1'b1;
    req = '0;
    @(negedge clk);
    srst = 1'b0;
    chk("srst_grant", 32'(grant), 32'd0);
    chk("srst_busy", 32'(busy), 32'd0);
    chk("srst_ack", 32'(ack), 32'd0);
    m_ptr = 0;
    @(negedge clk);

    // all four held: fair order from pointer 0
    for (int i = 0; i < 5; i++) begin
      start_txn(4'b1111, w);
      chk("rr_order", 32'(grant_id), 32'(order[i]));
      finish_txn(w, $urandom_range(1, 4), 1'b0);
    end
    req = '0;
    @(negedge clk);

    // enable low during WAIT with core_done pulsing: frozen, no ack
    start_txn(4'b0010, w);
    @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      core_done = k[0] ? 1'b0 : 1'b1;
      @(negedge clk);
      chk("frozen_ack", 32'(ack), 32'd0);
      chk("frozen_busy", 32'(busy), 32'd1);
      chk("frozen_grant", 32'(grant), 32'h2);
    end
    core_done = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_freeze_ack", 32'(ack), 32'd0);
    finish_txn(w, 0, 1'b1);

    // no core_done: timeout abort if built in, otherwise hang in WAIT
    start_txn(4'b0001, w);
`ifdef XFIRE_SCHED_TIMEOUT_EN
    cyc = 0;
    for (int k = 1; k <= 40 && cyc == 0; k++) begin
      @(negedge clk);
      if (ack != '0) cyc = k;
    end
    chk("to_latency", 32'(cyc), 32'(TIMEOUT + 1));
    chk("to_ack", 32'(ack), 32'h1);
    chk("to_err", 32'(timeout_err), 32'd1);
    req = '0;
    @(negedge clk);
    chk("to_busy_low", 32'(busy), 32'd0);
    m_ptr = (w + 1) % NREQ;
`else
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (ack != '0 || timeout_err) cyc++;
    end
    chk("hang_no_ack", 32'(cyc), 32'd0);
    chk("hang_busy", 32'(busy), 32'd1);
    finish_txn(w, 0, 1'b1);
`endif

    // asynchronous reset in WAIT: outputs clear without waiting for a clock
    start_txn(4'b0100, w);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_grant_id", 32'(grant_id), 32'd0);
    req = '0;
    @(negedge clk);
    arst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);

    // pointer back at 0; request withdrawn after grant still completes
    start_txn(4'b0011, w);
    req = '0;
    finish_txn(w, 2, 1'b1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
